// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the unified instruction/data memory.
// Port 0 is the multicycle core, port 1 the loader/debug master. Each access
// takes two cycles: a grant cycle (IDLE -> ACCESS) and a completion edge that
// returns read data with a one-cycle rvalid pulse.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state;
    logic   last;       // port granted most recently
    logic   sel;        // port owning the access in flight
    logic   any_req_c;
    logic   pick_c;

    // Round-robin choice: a lone requester wins, a tie goes to the port that was not served last.
    always_comb begin
        any_req_c = m0_req | m1_req;
        pick_c    = 1'b0;
        if (m0_req && m1_req) begin
            pick_c = ~last;
        end else if (m1_req) begin
            pick_c = 1'b1;
        end
    end

    // Arbitration FSM with registered grant, memory drive and read-return outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            sel       <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        sel       <= pick_c;
                        last      <= pick_c;
                        mem_addr  <= pick_c ? m1_addr  : m0_addr;
                        mem_wdata <= pick_c ? m1_wdata : m0_wdata;
                        mem_we    <= pick_c ? m1_we    : m0_we;
                        m0_gnt    <= ~pick_c;
                        m1_gnt    <= pick_c;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes commit on this edge; reads capture the memory output.
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                    if (!mem_we) begin
                        if (sel) begin
                            m1_rdata  <= mem_rdata;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= mem_rdata;
                            m0_rvalid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a word memory model behind the arbiter,
// a transaction-level reference model, directed scenarios and random traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, busy;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory array the arbiter drives: combinational read, write on the clock edge.
    logic [31:0] mem [64] = '{4: 32'hDEADBEEF, default: 32'h0};
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction accepted per free IDLE cycle, completed on the next edge.
    logic [31:0] ref_mem [64] = '{4: 32'hDEADBEEF, default: 32'h0};
    logic        m_last, pend, pend_we;
    int          pend_p;
    logic [31:0] pend_a, pend_d;
    logic        e_gnt0, e_gnt1, e_rv0, e_rv1, e_we, e_busy;
    logic [31:0] e_rd0, e_rd1, e_addr, e_wd;

    always @(posedge clk or negedge reset) begin
        int p;
        if (!reset) begin
            m_last = 1'b1; pend = 1'b0; pend_we = 1'b0; pend_p = 0;
            pend_a = '0; pend_d = '0;
            e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0; e_busy = 0;
            e_rd0 = '0; e_rd1 = '0; e_addr = '0; e_wd = '0;
        end else begin
            e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0; e_busy = 0;
            if (pend) begin
                if (pend_we) ref_mem[pend_a[7:2]] = pend_d;
                else if (pend_p == 0) begin e_rd0 = ref_mem[pend_a[7:2]]; e_rv0 = 1; end
                else begin e_rd1 = ref_mem[pend_a[7:2]]; e_rv1 = 1; end
                pend = 1'b0;
            end else if (m0_req || m1_req) begin
                if (m0_req && m1_req) p = m_last ? 0 : 1;
                else p = m1_req ? 1 : 0;
                m_last  = (p == 1);
                pend    = 1'b1;
                pend_p  = p;
                pend_we = (p == 1) ? m1_we : m0_we;
                pend_a  = (p == 1) ? m1_addr : m0_addr;
                pend_d  = (p == 1) ? m1_wdata : m0_wdata;
                e_gnt0  = (p == 0);
                e_gnt1  = (p == 1);
                e_busy  = 1;
                e_addr  = pend_a;
                e_wd    = pend_d;
                e_we    = pend_we;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (reset) begin
            check("m0_gnt", 32'(m0_gnt), 32'(e_gnt0));
            check("m1_gnt", 32'(m1_gnt), 32'(e_gnt1));
            check("m0_rvalid", 32'(m0_rvalid), 32'(e_rv0));
            check("m1_rvalid", 32'(m1_rvalid), 32'(e_rv1));
            check("m0_rdata", m0_rdata, e_rd0);
            check("m1_rdata", m1_rdata, e_rd1);
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wd);
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("busy", 32'(busy), 32'(e_busy));
            check("gnt_rvalid_overlap0", 32'(m0_gnt & m0_rvalid), 32'd0);
            check("gnt_rvalid_overlap1", 32'(m1_gnt & m1_rvalid), 32'd0);
            check("rvalid_both", 32'(m0_rvalid & m1_rvalid), 32'd0);
        end
    end

    // Event counters used by the directed scenarios.
    int we_cnt = 0, rv0_cnt = 0, rv1_cnt = 0, g0_cnt = 0;
    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (m0_rvalid) rv0_cnt++;
        if (m1_rvalid) rv1_cnt++;
        if (m0_gnt) g0_cnt++;
    end

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
        else begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
    endtask

    // Raise a request and hold it until the grant is seen; returns in the ACCESS cycle.
    task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        int   n;
        logic g;
        n = 0;
        g = 1'b0;
        drive(p, 1'b1, w, a, d);
        while (!g && n < 20) begin
            @(posedge clk); #1;
            n++;
            g = (p == 1) ? m1_gnt : m0_gnt;
        end
        check("gnt_seen", 32'(g), 32'd1);
        drive(p, 1'b0, w, a, d);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        reset = 1'b1;
    endtask

    task automatic rand_port(input int p, input int count);
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(3)) @(posedge clk);
            #1;
            do_req(p, 1'($urandom_range(1)), {24'h0, 6'($urandom_range(63)), 2'b00}, $urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, g0, v0, c0;
        int gport[$];
        int gcyc[$];

        apply_reset();

        // Single read of preloaded word on port 0.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, '0);
        @(posedge clk); #1;
        check("B_m0_gnt", 32'(m0_gnt), 32'd1);
        check("B_mem_addr", mem_addr, 32'h10);
        check("B_busy", 32'(busy), 32'd1);
        drive(0, 1'b0, 1'b0, 32'h10, '0);
        @(posedge clk); #1;
        check("B_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("B_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("B_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("B_m1_rdata", m1_rdata, 32'd0);

        // Port 1 write then read back.
        w0 = we_cnt; r0 = rv1_cnt;
        do_req(1, 1'b1, 32'h20, 32'h12345678);
        repeat (2) @(posedge clk); #1;
        check("C_we_cycles", 32'(we_cnt - w0), 32'd1);
        check("C_no_rvalid_on_write", 32'(rv1_cnt - r0), 32'd0);
        do_req(1, 1'b0, 32'h20, '0);
        @(posedge clk); #1;
        check("C_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("C_m1_rdata", m1_rdata, 32'h12345678);

        // Both ports held after reset: grants alternate starting with port 0.
        apply_reset();
        drive(0, 1'b1, 1'b0, 32'h0, '0);
        drive(1, 1'b1, 1'b0, 32'h4, '0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (m0_gnt) begin gport.push_back(0); gcyc.push_back(i); end
            if (m1_gnt) begin gport.push_back(1); gcyc.push_back(i); end
        end
        drive(0, 1'b0, 1'b0, 32'h0, '0);
        drive(1, 1'b0, 1'b0, 32'h4, '0);
        check("D_grant_count", 32'(gport.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("D_grant_port", 32'((k < gport.size()) ? gport[k] : -1), 32'(k % 2));
            check("D_grant_cycle", 32'((k < gcyc.size()) ? gcyc[k] : -1), 32'(2 * k + 1));
        end
        repeat (2) @(posedge clk); #1;

        // Tie after a lone port-1 grant goes to port 0.
        do_req(1, 1'b0, 32'h8, '0);
        drive(0, 1'b1, 1'b0, 32'hC, '0);
        drive(1, 1'b1, 1'b0, 32'h10, '0);
        repeat (2) @(posedge clk); #1;
        check("E_tie_m0_gnt", 32'(m0_gnt), 32'd1);
        check("E_tie_m1_gnt", 32'(m1_gnt), 32'd0);
        drive(0, 1'b0, 1'b0, 32'hC, '0);
        repeat (2) @(posedge clk); #1;
        check("E_m1_gnt_next", 32'(m1_gnt), 32'd1);
        drive(1, 1'b0, 1'b0, 32'h10, '0);
        repeat (2) @(posedge clk); #1;

        // Reset during the ACCESS cycle of a write aborts it.
        drive(0, 1'b1, 1'b1, 32'h30, 32'hAAAA5555);
        @(posedge clk); #1;
        check("F_mem_we_before", 32'(mem_we), 32'd1);
        drive(0, 1'b0, 1'b0, 32'h30, '0);
        #2 reset = 1'b0;
        #1;
        check("F_mem_we_async", 32'(mem_we), 32'd0);
        check("F_gnt_async", 32'(m0_gnt), 32'd0);
        check("F_busy_async", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        check("F_mem30_unchanged", mem[12], 32'h0);
        drive(0, 1'b1, 1'b0, 32'h30, '0);
        drive(1, 1'b1, 1'b0, 32'h34, '0);
        @(posedge clk); #1;
        check("F_tie_m0_gnt", 32'(m0_gnt), 32'd1);
        check("F_tie_m1_gnt", 32'(m1_gnt), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h30, '0);
        repeat (2) @(posedge clk); #1;
        check("F_m1_gnt_next", 32'(m1_gnt), 32'd1);
        drive(1, 1'b0, 1'b0, 32'h34, '0);
        repeat (2) @(posedge clk); #1;

        // Request held three cycles past its grant becomes a second transaction.
        g0 = g0_cnt; v0 = rv0_cnt;
        drive(0, 1'b1, 1'b0, 32'h10, '0);
        repeat (4) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h10, '0);
        repeat (3) @(posedge clk); #1;
        check("G_gnt_count", 32'(g0_cnt - g0), 32'd2);
        check("G_rvalid_count", 32'(rv0_cnt - v0), 32'd2);

        // Random concurrent traffic on both ports, checked by the model every cycle.
        c0 = nchk;
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        repeat (3) @(posedge clk); #1;
        check("H_random_checked", 32'(nchk > c0 + 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory between the multicycle core (port 0) and a program loader/debug master (port 1). It sits between the requesters and the memory array's `A`/`WD`/`WE`/`RD` pins. It serialises accesses with a registered request/grant handshake and round-robin fairness, and returns read data with a one-cycle valid pulse. The core's fetch and load/store path reaches memory only through this block.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held until the matching `mN_gnt` is seen.
- `m0_we`, `m1_we`  in  1  write enable (1 = write, 0 = read); stable while `mN_req` is high.
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address; stable while `mN_req` is high.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data; stable while `mN_req` is high.
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse; the request was accepted.
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse; `mN_rdata` holds the read result.
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data, held until the next read completes on that port.
- `mem_addr`  out  ADDR_W  memory address, registered.
- `mem_wdata`  out  DATA_W  memory write data, registered.
- `mem_we`  out  1  memory write enable, registered.
- `mem_rdata`  in  DATA_W  memory read data, combinational from `mem_addr`.
- `busy`  out  1  high while in ACCESS.

## Operation
- FSM has two states, IDLE and ACCESS. `last` is a 1-bit round-robin pointer that holds the port granted most recently.
- **In IDLE:**
  - If neither port requests, stay in IDLE.
  - If exactly one port requests, that port is selected.
  - If both request, the port ≠ `last` is selected.
  - On selection, at the clock edge: latch the selected addr/wdata/we into `mem_addr`/`mem_wdata`/`mem_we`, set `sel`, set `last` = `sel`, assert `gnt[sel]`, and go to ACCESS.
- **In ACCESS:**
  - Memory is driven from the latched registers and all requests are ignored.
  - At the edge:
    - Clear `gnt` and `mem_we`.
    - For a read, capture `mem_rdata` into `m{sel}_rdata` and pulse `m{sel}_rvalid`.
    - Return to IDLE.
- Writes commit at the end of the ACCESS cycle. No rvalid is generated for a write.
- `mem_addr`/`mem_wdata` keep their last values in IDLE; only `mem_we` is cleared.
- Requesters drop `req`, or present a new request, in the cycle after they see `gnt`.
  - A `req` still high in the IDLE cycle following ACCESS is treated as a new transaction.
- The arbiter performs no address decoding, alignment checks or width conversion. Addresses pass through unchanged.

## Timing
- Reset values (asynchronous, while `reset` = 0):
  - state = IDLE, `last` = 1 (so port 0 wins the first tie), `sel` = 0.
  - All `gnt`/`rvalid`/`mem_we`/`busy` = 0.
  - `mem_addr`, `mem_wdata`, `m0_rdata`, `m1_rdata` = 0.
- `req` sampled in cycle t → `gnt` and `busy` high in t+1, with memory driven during t+1 → `rvalid` high in t+2 for reads.
- Throughput: one access per 2 cycles. Back-to-back requests are accepted in the same IDLE cycle in which the previous `rvalid` is high.
- Both ports requesting continuously → grants alternate 0,1,0,1…. Neither port waits more than one transaction.
- Reset asserted during ACCESS aborts the transaction:
  - `mem_we` drops immediately.
  - No rvalid is issued.
  - The write may be lost, and the requester must reissue it.
- `gnt` and `rvalid` never overlap on the same port in the same cycle. Both ports' `rvalid` are never high in the same cycle.

## Test plan
- Reset then single read: preload mem[0x10] = 0xDEADBEEF, pulse `m0_req` read 0x10 at cycle 0 → `m0_gnt` in cycle 1, `mem_addr` = 0x10, `m0_rvalid` in cycle 2 with `m0_rdata` = 0xDEADBEEF. Port 1 outputs stay 0.
- Write then read, port 1: write 0x20 ← 0x12345678, then read 0x20 → `mem_we` high exactly one cycle, no `m1_rvalid` for the write, read returns 0x12345678.
- Simultaneous requests after reset: both read (m0 @0x0, m1 @0x4) → m0 granted first and m1 two cycles later. Holding both requested → grant order 0,1,0,1 over 8 cycles.
- Tie after a port-1 grant: `last` = 1 with a lone m1 request, then both request → m0 granted next.
- Reset mid-write: assert `reset` low during ACCESS of write 0x30 ← 0xAAAA5555 → `mem_we`, `gnt` and `busy` fall asynchronously, mem[0x30] unchanged, and after release port 0 wins the first tie.
- Held request: m0 keeps `req` high for 3 cycles after `gnt` → two transactions are issued; the bench checks that exactly one `gnt` occurs per transaction.
